// File: rtl/lzx_74hc194.sv
// lzx_74hc194: 4-bit bidirectional universal shift register (74HC194 equivalent).
// Modes by S: 00 hold, 01 shift right (toward Q[3], DSR enters Q[0]),
// 10 shift left (toward Q[0], DSL enters Q[3]), 11 parallel load.
// MR clears the register asynchronously; Q comes straight from the flops.
module lzx_74hc194 (
  input  logic       MR,
  input  logic       CLK,
  input  logic       DSR,
  input  logic       DSL,
  input  logic [1:0] S,
  input  logic [3:0] D,
  output logic [3:0] Q
);

  logic [3:0] q_reg;
  logic [3:0] q_next;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      // Neighbour feeding this bit on a right shift (lower bit, or DSR at the bottom)
      // and on a left shift (upper bit, or DSL at the top). No wrap-around.
      logic from_lower;
      logic from_upper;
      logic bit_next;

      if (gi == 0) begin : g_low_edge
        assign from_lower = DSR;
      end else begin : g_low_inner
        assign from_lower = q_reg[gi-1];
      end

      if (gi == 3) begin : g_high_edge
        assign from_upper = DSL;
      end else begin : g_high_inner
        assign from_upper = q_reg[gi+1];
      end

      // Per-bit mode mux; any unmatched S (including X/Z in simulation) holds.
      always_comb begin
        bit_next = q_reg[gi];
        case (S)
          2'b01:   bit_next = from_lower;
          2'b10:   bit_next = from_upper;
          2'b11:   bit_next = D[gi];
          default: bit_next = q_reg[gi];
        endcase
      end

      assign q_next[gi] = bit_next;
    end
  endgenerate

  // State register: asynchronous clear dominates, otherwise take the selected mode.
  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      q_reg <= 4'b0000;
    end else begin
      q_reg <= q_next;
    end
  end

  assign Q = q_reg;

endmodule

// File: tb/tb_lzx_74hc194.sv
// Directed testbench for lzx_74hc194: reset, load, shifts, hold, reset mid-shift.
module tb_lzx_74hc194;

  logic       mr;
  logic       clk;
  logic       dsr;
  logic       dsl;
  logic [1:0] s;
  logic [3:0] d;
  logic [3:0] q;

  int checks = 0;
  int errors = 0;

  lzx_74hc194 dut (
    .MR  (mr),
    .CLK (clk),
    .DSR (dsr),
    .DSL (dsl),
    .S   (s),
    .D   (d),
    .Q   (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mr = 1'b1; s = 2'b00; d = 4'h0; dsr = 1'b0; dsl = 1'b0;
    #2;
    checks++;
    if (q !== 4'h0) begin
      errors++;
      $display("FAIL reset_initial q=%b expected=%b", q, 4'h0);
    end
    // Load 4'hA with reset released
    tick();
    mr = 1'b0; s = 2'b11; d = 4'hA;
    tick();
    checks++;
    if (q !== 4'hA) begin
      errors++;
      $display("FAIL reset_preload q=%b expected=%b", q, 4'hA);
    end
    $display("reset: preload q=%b", q);
    // Pulse MR between edges: clear is immediate
    #1;
    mr = 1'b1;
    #1;
    checks++;
    if (q !== 4'h0) begin
      errors++;
      $display("FAIL reset_async_clear q=%b expected=%b", q, 4'h0);
    end
    $display("reset: async clear q=%b", q);
    // Clock with load of F while MR held: stays 0
    s = 2'b11; d = 4'hF;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (q !== 4'h0) begin
        errors++;
        $display("FAIL reset_held_edge%0d q=%b expected=%b", i, q, 4'h0);
      end
      $display("reset: held edge %0d q=%b", i, q);
    end
    // Load F, then raise MR coincident with a clock edge: reset wins
    mr = 1'b0;
    tick();
    checks++;
    if (q !== 4'hF) begin
      errors++;
      $display("FAIL reset_reload q=%b expected=%b", q, 4'hF);
    end
    @(posedge clk);
    mr = 1'b1;
    #1;
    checks++;
    if (q !== 4'h0) begin
      errors++;
      $display("FAIL reset_coincident q=%b expected=%b", q, 4'h0);
    end
    $display("reset: coincident edge q=%b", q);
    mr = 1'b0;
  endtask

  task automatic test_load();
    s = 2'b11; d = 4'h5;
    tick();
    checks++;
    if (q !== 4'b0101) begin
      errors++;
      $display("FAIL load_5 q=%b expected=%b", q, 4'b0101);
    end
    $display("load: d=5 q=%b", q);
    // D changes between edges have no effect
    d = 4'hA;
    #3;
    checks++;
    if (q !== 4'b0101) begin
      errors++;
      $display("FAIL load_d_change_no_edge q=%b expected=%b", q, 4'b0101);
    end
    $display("load: d->A between edges q=%b", q);
  endtask

  task automatic test_shift_right();
    logic [3:0] exp_q [3];
    exp_q[0] = 4'b1011; exp_q[1] = 4'b0111; exp_q[2] = 4'b1111;
    s = 2'b01; dsr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== exp_q[i]) begin
        errors++;
        $display("FAIL shift_right_edge%0d q=%b expected=%b", i + 1, q, exp_q[i]);
      end
      $display("shift_right: edge %0d q=%b", i + 1, q);
    end
  endtask

  task automatic test_shift_left();
    logic [3:0] exp_q [7];
    exp_q[0] = 4'b0011; exp_q[1] = 4'b0001; exp_q[2] = 4'b0000;
    exp_q[3] = 4'b1000; exp_q[4] = 4'b1100; exp_q[5] = 4'b1110; exp_q[6] = 4'b1111;
    s = 2'b11; d = 4'b0111;
    tick();
    checks++;
    if (q !== 4'b0111) begin
      errors++;
      $display("FAIL shift_left_preload q=%b expected=%b", q, 4'b0111);
    end
    s = 2'b10; dsl = 1'b0; dsr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) dsl = 1'b1;
      tick();
      checks++;
      if (q !== exp_q[i]) begin
        errors++;
        $display("FAIL shift_left_edge%0d q=%b expected=%b", i + 1, q, exp_q[i]);
      end
      $display("shift_left: edge %0d dsl=%b q=%b", i + 1, dsl, q);
    end
  endtask

  task automatic test_hold();
    s = 2'b11; d = 4'b1011;
    tick();
    s = 2'b00;
    for (int i = 0; i < 3; i++) begin
      d = ~d; dsr = ~dsr; dsl = ~dsl;
      tick();
      checks++;
      if (q !== 4'b1011) begin
        errors++;
        $display("FAIL hold_edge%0d q=%b expected=%b", i + 1, q, 4'b1011);
      end
      $display("hold: edge %0d d=%b q=%b", i + 1, d, q);
    end
  endtask

  task automatic test_reset_mid_shift();
    s = 2'b11; d = 4'h0;
    tick();
    s = 2'b01; dsr = 1'b1;
    tick();
    tick();
    checks++;
    if (q !== 4'b0011) begin
      errors++;
      $display("FAIL mid_shift_progress q=%b expected=%b", q, 4'b0011);
    end
    mr = 1'b1;
    #1;
    checks++;
    if (q !== 4'h0) begin
      errors++;
      $display("FAIL mid_shift_clear q=%b expected=%b", q, 4'h0);
    end
    $display("mid_shift: MR asserted q=%b", q);
    tick();
    checks++;
    if (q !== 4'h0) begin
      errors++;
      $display("FAIL mid_shift_held q=%b expected=%b", q, 4'h0);
    end
    #2;
    mr = 1'b0;
    #1;
    checks++;
    if (q !== 4'h0) begin
      errors++;
      $display("FAIL mid_shift_release_no_edge q=%b expected=%b", q, 4'h0);
    end
    tick();
    checks++;
    if (q !== 4'b0001) begin
      errors++;
      $display("FAIL mid_shift_first_edge q=%b expected=%b", q, 4'b0001);
    end
    $display("mid_shift: first edge after release q=%b", q);
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift_right();
    test_shift_left();
    test_hold();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout q=%b expected=finish", q);
    $fatal(1, "timeout");
  end

endmodule
